// File: rtl/step_ramp_ctrl.sv
// Trapezoidal-profile move controller feeding a full-step coil sequencer.
// Emits one-cycle step strobes with linear accel/cruise/decel and tracks absolute position.
module step_ramp_ctrl #(
    parameter int START_DLY = 500000,
    parameter int MIN_DLY   = 100000,
    parameter int DLY_STEP  = 4000,
    parameter int CNT_W     = 20,
    parameter int STEP_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir_in,
    input  logic [STEP_W-1:0]    steps,
    input  logic                 abort,
    output logic                 step_o,
    output logic                 dir_o,
    output logic                 busy,
    output logic                 done,
    output logic signed [31:0]   pos
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] START_C = CNT_W'(START_DLY);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DLY);
    localparam logic [CNT_W:0]   START_X = (CNT_W+1)'(START_DLY);
    localparam logic [CNT_W:0]   MIN_X   = (CNT_W+1)'(MIN_DLY);
    localparam logic [CNT_W:0]   DLY_X   = (CNT_W+1)'(DLY_STEP);

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     rem_q, rem_d;
    logic [STEP_W-1:0]     ramp_q, ramp_d;
    logic [CNT_W-1:0]      ivl_q, ivl_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic                  dir_q, dir_d;
    logic signed [31:0]    pos_q, pos_d;
    logic [STEP_W-1:0]     rem_m;
    logic                  moving;
    logic                  strobe;

    // Interval arithmetic is done one bit wider so it saturates instead of wrapping.
    function automatic logic [CNT_W-1:0] ivl_slower(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        s = {1'b0, v} + DLY_X;
        if (s > START_X) s = START_X;
        return s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] ivl_faster(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        if ({1'b0, v} < MIN_X + DLY_X) s = MIN_X;
        else                           s = {1'b0, v} - DLY_X;
        return s[CNT_W-1:0];
    endfunction

    assign moving = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
    assign strobe = moving && (timer_q == ivl_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            ramp_q  <= '0;
            ivl_q   <= '0;
            timer_q <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ramp_q  <= ramp_d;
            ivl_q   <= ivl_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ramp_d  = ramp_q;
        ivl_d   = ivl_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        rem_m   = rem_q - STEP_W'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir_in;
                        ivl_d   = START_C;
                        timer_d = '0;
                        ramp_d  = '0;
                        state_d = S_ACCEL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (strobe) begin
                    timer_d = '0;
                    rem_d   = rem_m;
                    pos_d   = dir_q ? pos_q - 32'sd1 : pos_q + 32'sd1;
                    if (rem_m == '0) begin
                        state_d = S_DONE;
                    end else if (rem_m <= ramp_q) begin
                        state_d = S_DECEL;
                        ivl_d   = ivl_slower(ivl_q);
                        ramp_d  = ramp_q - STEP_W'(1);
                    end else if (state_q == S_ACCEL) begin
                        ivl_d  = ivl_faster(ivl_q);
                        ramp_d = ramp_q + STEP_W'(1);
                        if (ivl_d == MIN_C) state_d = S_CRUISE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
                // Abort clamps the post-strobe remainder so the decel leg can still run out.
                if (abort && ({1'b0, rem_d} > {1'b0, ramp_d} + (STEP_W+1)'(1)))
                    rem_d = ramp_d + STEP_W'(1);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_o = strobe;
        busy   = moving;
        done   = (state_q == S_DONE);
        dir_o  = dir_q;
        pos    = pos_q;
    end

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Bench for step_ramp_ctrl: directed vector table, multi-cycle corner sequences,
// and random moves checked against a step-level profile model.
module tb_step_ramp_ctrl;

    localparam int S = 10;
    localparam int M = 4;
    localparam int D = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               dir_in;
    logic [15:0]        steps;
    logic               abort;
    logic               step_o;
    logic               dir_o;
    logic               busy;
    logic               done;
    logic signed [31:0] pos;

    step_ramp_ctrl #(
        .START_DLY(S), .MIN_DLY(M), .DLY_STEP(D), .CNT_W(8), .STEP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .steps(steps),
        .abort(abort), .step_o(step_o), .dir_o(dir_o), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int got_q[$];
    int exp_q[$];
    int exp_pos = 0;

    typedef struct {
        int steps;
        bit dir;
        int ab_s;
        int ab_d;
        int exp_n;
        int exp_dpos;
    } vec_t;

    vec_t vtab[4];
    int   ivl_tab[4][12];

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Step-level profile: walk the move one step at a time; abort clamps the
    // state that is live at the abort cycle.
    function automatic void model(input int n, input int ab_s, input int ab_d);
        int ivl, ramp, rem, t_now, k, t_ab;
        bit accel;
        exp_q.delete();
        ivl = S; ramp = 0; rem = n; accel = 1; t_now = 0; k = 0; t_ab = -1;
        while (rem > 0) begin
            t_now += ivl;
            exp_q.push_back(ivl);
            k++;
            rem--;
            if (rem == 0) break;
            if (rem <= ramp) begin
                ivl = (ivl + D > S) ? S : ivl + D;
                ramp--;
                accel = 0;
            end else if (accel) begin
                ivl = (ivl - D < M) ? M : ivl - D;
                ramp++;
                if (ivl == M) accel = 0;
            end
            if (k == ab_s) t_ab = t_now + ab_d;
            if (t_ab >= t_now && t_ab < t_now + ivl && rem > ramp + 1) rem = ramp + 1;
        end
    endfunction

    task automatic run_move(input int n, input bit d, input int ab_s, input int ab_d);
        int last, ns, t_ab;
        bit seen_done, bad_busy, bad_dir, done_after;
        got_q.delete();
        ns = 0; t_ab = -1; last = 0;
        seen_done = 0; bad_busy = 0; bad_dir = 0;
        @(negedge clk);
        start = 1'b1; steps = n[15:0]; dir_in = d;
        for (int t = 1; t <= 2000; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (step_o) begin
                got_q.push_back(t - last);
                last = t;
                ns++;
                if (ns == ab_s) t_ab = t + ab_d;
            end
            if (t == t_ab) abort = 1'b1;
            if (done) begin
                seen_done = 1;
                if (busy) bad_busy = 1;
                break;
            end
            if (!busy) bad_busy = 1;
            if (dir_o != d) bad_dir = 1;
        end
        @(negedge clk);
        abort = 1'b0;
        done_after = done | busy;
        check("done_seen", seen_done, 1);
        check("busy_profile", bad_busy, 0);
        check("dir_stable", bad_dir, 0);
        check("done_one_cycle", done_after, 0);
    endtask

    task automatic compare_move(input string name, input int exp_n);
        check({name, "_count"}, got_q.size(), exp_n);
        for (int i = 0; i < exp_q.size(); i++)
            check({name, "_ivl"}, (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        check({name, "_pos"}, pos, exp_pos);
    endtask

    initial begin
        int st_q[$];
        int last, td, td2, t_rst;
        bit bad;

        vtab[0] = '{steps: 8,   dir: 0, ab_s: 0, ab_d: 0, exp_n: 8, exp_dpos: 8};
        vtab[1] = '{steps: 3,   dir: 1, ab_s: 0, ab_d: 0, exp_n: 3, exp_dpos: -3};
        vtab[2] = '{steps: 0,   dir: 0, ab_s: 0, ab_d: 0, exp_n: 0, exp_dpos: 0};
        vtab[3] = '{steps: 100, dir: 0, ab_s: 5, ab_d: 2, exp_n: 9, exp_dpos: 9};
        ivl_tab[0] = '{10, 8, 6, 4, 4, 6, 8, 10, 0, 0, 0, 0};
        ivl_tab[1] = '{10, 8, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ivl_tab[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ivl_tab[3] = '{10, 8, 6, 4, 4, 4, 6, 8, 10, 0, 0, 0};

        rst = 1'b1; start = 1'b0; dir_in = 1'b0; steps = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_step", step_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dir", dir_o, 0);
        check("rst_pos", pos, 0);

        for (int v = 0; v < 4; v++) begin
            run_move(vtab[v].steps, vtab[v].dir, vtab[v].ab_s, vtab[v].ab_d);
            exp_pos += vtab[v].exp_dpos;
            exp_q.delete();
            for (int i = 0; i < vtab[v].exp_n; i++) exp_q.push_back(ivl_tab[v][i]);
            compare_move("table", vtab[v].exp_n);
        end

        // Ignored mid-move start, then reset between strobes.
        @(negedge clk);
        start = 1'b1; steps = 16'd20; dir_in = 1'b0;
        got_q.delete(); last = 0; bad = 0; t_rst = -1;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (step_o) begin
                got_q.push_back(t - last);
                last = t;
                if (got_q.size() == 3) begin start = 1'b1; steps = 16'd5; dir_in = 1'b1; end
                if (got_q.size() == 4) t_rst = t + 2;
            end
            if (busy && dir_o != 1'b0) bad = 1;
            if (t == t_rst) begin rst = 1'b1; break; end
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_step", step_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pos", pos, 0);
        check("midstart_dir", bad, 0);
        exp_q = '{10, 8, 6, 4};
        for (int i = 0; i < 4; i++)
            check("midstart_ivl", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || step_o || busy) bad = 1;
        end
        check("midrst_quiet", bad, 0);
        exp_pos = 0;
        run_move(2, 1'b1, 0, 0);
        model(2, 0, 0);
        exp_pos -= 2;
        compare_move("post_rst", 2);

        // Start held high across done: second move is accepted in the following IDLE cycle.
        @(negedge clk);
        start = 1'b1; steps = 16'd2; dir_in = 1'b0;
        st_q.delete(); td = -1; td2 = -1;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (step_o) st_q.push_back(t);
            if (done) begin
                if (td < 0) td = t;
                else begin td2 = t; break; end
            end
            if (td >= 0 && t == td + 2) start = 1'b0;
        end
        start = 1'b0;
        exp_q = '{10, 18, 30, 38};
        check("b2b_count", st_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("b2b_strobe_t", (i < st_q.size()) ? st_q[i] : -1, exp_q[i]);
        check("b2b_done1_t", td, 19);
        check("b2b_done2_t", td2, 39);
        exp_pos += 4;
        @(negedge clk);
        check("b2b_pos", pos, exp_pos);

        for (int r = 0; r < 25; r++) begin
            int n, ab_s, ab_d;
            bit d;
            n = $urandom_range(0, 30);
            d = 1'($urandom_range(0, 1));
            ab_s = 0; ab_d = 0;
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                ab_s = $urandom_range(1, n);
                ab_d = $urandom_range(0, 12);
            end
            run_move(n, d, ab_s, ab_d);
            model(n, ab_s, ab_d);
            exp_pos += d ? -exp_q.size() : exp_q.size();
            compare_move("rand", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
